fibo_seq_ctrl: RTL and testbench

//   Request/response controller that sequences an adder + two-register Fibonacci datapath.
//   - Accepts a term index n and steps the datapath n times.
//   - Returns F(n) (F(0)=0, F(1)=1) together with an overflow flag.
//   - Replaces free-running generation with on-demand computation for bus-side clients.

---
 rtl/fibo_seq_ctrl_pkg.sv | 14 +
 rtl/fibo_step_dp.sv | 66 ++++++
 rtl/fibo_seq_ctrl.sv | 103 ++++++++++
 tb/tb_fibo_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibo_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci sequencer: FSM state encoding and
// the F(0)/F(1) seed values loaded into the datapath on request accept.
package fibo_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FiboSeed0 = 0;  // F(0)
  localparam int unsigned FiboSeed1 = 1;  // F(1)

endpackage

// File: rtl/fibo_step_dp.sv
// Two-register Fibonacci datapath with sticky overflow tracking.
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset
//   load    in   seed a=F(0), b=F(1), clear overflow flags
//   step    in   advance one term: a<=b, b<=a+b
//   a       out  current term F(k) mod 2^WIDTH
//   a_ovf   out  1 when the true F(k) does not fit in WIDTH bits
module fibo_step_dp
  import fibo_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] a,
  output logic             a_ovf
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;
  logic [WIDTH:0]   sum;

  // One extra bit so the carry out of the wrapped add is visible.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    if (load) begin
      a_d     = WIDTH'(FiboSeed0);
      b_d     = WIDTH'(FiboSeed1);
      a_ovf_d = 1'b0;
      b_ovf_d = 1'b0;
    end else if (step) begin
      a_d     = b_q;
      b_d     = sum[WIDTH-1:0];
      a_ovf_d = b_ovf_q;
      // Sticky: once either operand has wrapped, every later term is too big.
      b_ovf_d = sum[WIDTH] | a_ovf_q | b_ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
    end
  end

  assign a     = a_q;
  assign a_ovf = a_ovf_q;

endmodule

// File: rtl/fibo_seq_ctrl.sv
// Request/response controller computing F(n) on demand.
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  high in IDLE
//   req_idx    in   term index n, sampled on request handshake
//   abort      in   cancel a computation in RUN (ignored in DONE)
//   rsp_valid  out  high in DONE
//   rsp_ready  in   consumer takes the result
//   rsp_value  out  F(n) mod 2^WIDTH, held until the next request
//   rsp_ovf    out  true F(n) >= 2^WIDTH
//   busy       out  state != IDLE
module fibo_seq_ctrl
  import fibo_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             load, step;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StRun;
          cnt_d   = req_idx;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - IDX_W'(1);
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath controls.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        load      = req_valid;
      end
      StRun:   step = !abort && (cnt_q != '0);
      StDone:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  fibo_step_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .step   (step),
    .a      (rsp_value),
    .a_ovf  (rsp_ovf)
  );

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Directed bench: a 16-bit and a 4-bit instance share all inputs so they
// stay in lock-step; the 4-bit instance exposes overflow behaviour.
module tb_fibo_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [5:0]  req_idx;
  logic        abort;
  logic        rsp_ready;

  logic        req_ready16, rsp_valid16, rsp_ovf16, busy16;
  logic [15:0] rsp_value16;
  logic        req_ready4, rsp_valid4, rsp_ovf4, busy4;
  logic [3:0]  rsp_value4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fibo_seq_ctrl #(.WIDTH(16), .IDX_W(6)) u_dut16 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready16),
    .req_idx  (req_idx),
    .abort    (abort),
    .rsp_valid(rsp_valid16),
    .rsp_ready(rsp_ready),
    .rsp_value(rsp_value16),
    .rsp_ovf  (rsp_ovf16),
    .busy     (busy16)
  );

  fibo_seq_ctrl #(.WIDTH(4), .IDX_W(6)) u_dut4 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready4),
    .req_idx  (req_idx),
    .abort    (abort),
    .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready),
    .rsp_value(rsp_value4),
    .rsp_ovf  (rsp_ovf4),
    .busy     (busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge (caller guarantees IDLE).
  task automatic issue(input logic [5:0] idx);
    req_valid = 1'b1;
    req_idx   = idx;
    tick();
    req_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until rsp_valid; -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid16 && lat < 100) begin
      tick();
      lat++;
    end
    if (!rsp_valid16) lat = -1;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({rsp_valid16, rsp_ovf16, busy16, req_ready16} !== 4'b0001 || rsp_value16 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_init: valid/ovf/busy/ready=%b value=%0d, required 0001 value=0",
               {rsp_valid16, rsp_ovf16, busy16, req_ready16}, rsp_value16);
    end
    tick();
    reset_n = 1'b1;
    tick();
    issue(6'd10);
    tick(); tick(); tick();  // a = F(3) = 2
    vectors++;
    if (busy16 !== 1'b1 || rsp_value16 !== 16'd2) begin
      miscompares++;
      $display("FAIL reset_pre_run: busy=%b value=%0d, required busy=1 value=2",
               busy16, rsp_value16);
    end
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid16, rsp_ovf16, busy16, req_ready16} !== 4'b0001 || rsp_value16 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run: valid/ovf/busy/ready=%b value=%0d, required 0001 value=0",
               {rsp_valid16, rsp_ovf16, busy16, req_ready16}, rsp_value16);
    end
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (req_ready16 !== 1'b1 || busy16 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0",
               req_ready16, busy16);
    end
  endtask

  task automatic test_sweep();
    logic [5:0]  idx [5] = '{6'd0, 6'd1, 6'd2, 6'd10, 6'd24};
    logic [15:0] exp [5] = '{16'd0, 16'd1, 16'd1, 16'd55, 16'd46368};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(idx[i]);
      wait_rsp(lat);
      vectors++;
      if (lat !== int'(idx[i]) + 1) begin
        miscompares++;
        $display("FAIL sweep_latency n=%0d: got %0d edges, required %0d", idx[i], lat, idx[i] + 1);
      end
      vectors++;
      if (rsp_value16 !== exp[i] || rsp_ovf16 !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_value n=%0d: got %0d ovf=%b, required %0d ovf=0",
                 idx[i], rsp_value16, rsp_ovf16, exp[i]);
      end
      handshake();
      vectors++;
      if (busy16 !== 1'b0 || rsp_valid16 !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_idle n=%0d: busy=%b valid=%b, required 0 0", idx[i], busy16,
                 rsp_valid16);
      end
    end
  endtask

  task automatic test_overflow();
    logic [5:0] idx [3] = '{6'd7, 6'd8, 6'd12};
    logic [3:0] exp [3] = '{4'd13, 4'd5, 4'd0};
    logic       eovf [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(idx[i]);
      wait_rsp(lat);
      vectors++;
      if (rsp_valid4 !== 1'b1 || rsp_value4 !== exp[i] || rsp_ovf4 !== eovf[i]) begin
        miscompares++;
        $display("FAIL ovf4 n=%0d: valid=%b value=%0d ovf=%b, required valid=1 value=%0d ovf=%b",
                 idx[i], rsp_valid4, rsp_value4, rsp_ovf4, exp[i], eovf[i]);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(6'd5);
    wait_rsp(lat);
    req_valid = 1'b1;
    req_idx   = 6'd9;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rsp_valid16 !== 1'b1 || rsp_value16 !== 16'd5 || req_ready16 !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure cyc=%0d: valid=%b value=%0d ready=%b, required 1 5 0",
                 i, rsp_valid16, rsp_value16, req_ready16);
      end
      tick();
    end
    req_valid = 1'b0;
    handshake();
    vectors++;
    if (busy16 !== 1'b0 || rsp_value16 !== 16'd5) begin
      miscompares++;
      $display("FAIL backpressure_after: busy=%b value=%0d, required busy=0 value=5",
               busy16, rsp_value16);
    end
  endtask

  task automatic test_abort();
    int lat;
    issue(6'd20);  // 1st RUN cycle
    tick();        // 2nd
    tick();        // 3rd
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (busy16 !== 1'b0 || rsp_valid16 !== 1'b0 || req_ready16 !== 1'b1 ||
        rsp_value16 !== 16'd1) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b valid=%b ready=%b value=%0d, required 0 0 1 value=1",
               busy16, rsp_valid16, req_ready16, rsp_value16);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (rsp_valid16 !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_rsp cyc=%0d: valid=%b, required 0", i, rsp_valid16);
      end
    end
    issue(6'd3);
    wait_rsp(lat);
    vectors++;
    if (lat !== 4 || rsp_value16 !== 16'd2) begin
      miscompares++;
      $display("FAIL abort_followup: lat=%0d value=%0d, required lat=4 value=2", lat,
               rsp_value16);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(6'd4);
    wait_rsp(lat);
    vectors++;
    if (rsp_value16 !== 16'd3) begin
      miscompares++;
      $display("FAIL b2b_first: value=%0d, required 3", rsp_value16);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_idx   = 6'd6;
    tick();
    rsp_ready = 1'b0;
    vectors++;
    if (busy16 !== 1'b0 || req_ready16 !== 1'b1 || rsp_valid16 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: busy=%b ready=%b valid=%b, required 0 1 0", busy16, req_ready16,
               rsp_valid16);
    end
    tick();
    req_valid = 1'b0;
    vectors++;
    if (busy16 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy16);
    end
    wait_rsp(lat);
    vectors++;
    if (lat !== 7 || rsp_value16 !== 16'd8 || rsp_ovf16 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d value=%0d ovf=%b, required lat=7 value=8 ovf=0", lat,
               rsp_value16, rsp_ovf16);
    end
    handshake();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_idx   = '0;
    abort     = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_sweep();
    test_overflow();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
